// File: rtl/movement_text_gen.sv
// IR sensor synchroniser/debouncer with frame-gated direction commit
// and registered text-row character address generation.
module movement_text_gen #(
    parameter int X_W             = 11,
    parameter int X_START         = 128,
    parameter int CHAR_W_LOG2     = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int IR_ACTIVE_LOW   = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [3:0]     ir,
    input  logic [X_W-1:0] x,
    input  logic           frame_tick,
    output logic [6:0]     char_addr_TEXT,
    output logic [3:0]     dir,
    output logic           dir_changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [X_W-1:0] X_START_V = X_W'(X_START);
    localparam int SLEN = 17;

    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       cand_q;
    logic [3:0]       stable_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       dir_q;
    logic             dir_chg_q;
    logic [6:0]       char_q;
    logic [6:0]       char_d;

    logic [3:0]        s_sync;
    logic [3:0]        dec;
    logic [8*SLEN-1:0] text_row;
    logic [X_W-1:0]    xoff;
    logic [X_W-1:0]    col;
    logic [7:0]        glyph;
    logic              in_text;

    assign s_sync = (IR_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    // Pairings first so opposing or diagonal pairs beat single sensors.
    always_comb begin
        dec = 4'd0;
        if (stable_q[0] && stable_q[1])      dec = 4'd9;
        else if (stable_q[2] && stable_q[3]) dec = 4'd9;
        else if (stable_q[2] && stable_q[1]) dec = 4'd5;
        else if (stable_q[3] && stable_q[1]) dec = 4'd6;
        else if (stable_q[2] && stable_q[0]) dec = 4'd7;
        else if (stable_q[3] && stable_q[0]) dec = 4'd8;
        else if (stable_q[0])                dec = 4'd2;
        else if (stable_q[1])                dec = 4'd1;
        else if (stable_q[2])                dec = 4'd4;
        else if (stable_q[3])                dec = 4'd3;
    end

    // Strings are left-justified and space-padded to a common length.
    always_comb begin
        text_row = {SLEN{8'h20}};
        case (dir_q)
            4'd0: text_row = {"HOVER ON SENSOR", {2{8'h20}}};
            4'd1: text_row = {"FORWARD", {10{8'h20}}};
            4'd2: text_row = {"BACK", {13{8'h20}}};
            4'd3: text_row = {"LEFT", {13{8'h20}}};
            4'd4: text_row = {"RIGHT", {12{8'h20}}};
            4'd5: text_row = "FORWARD AND RIGHT";
            4'd6: text_row = {"FORWARD AND LEFT", 8'h20};
            4'd7: text_row = {"BACK AND RIGHT", {3{8'h20}}};
            4'd8: text_row = {"BACK AND LEFT", {4{8'h20}}};
            4'd9: text_row = {"INVALID INPUT", {4{8'h20}}};
            default: text_row = {SLEN{8'h20}};
        endcase
    end

    always_comb begin
        xoff    = x - X_START_V;
        col     = xoff >> CHAR_W_LOG2;
        in_text = (x >= X_START_V) && (col < X_W'(SLEN));
        glyph   = 8'h20;
        for (int i = 0; i < SLEN; i++) begin
            if (col == X_W'(i)) glyph = text_row[8*(SLEN-1-i) +: 8];
        end
        char_d = (in_text && !glyph[7]) ? glyph[6:0] : 7'h20;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cand_q    <= '0;
            stable_q  <= '0;
            cnt_q     <= '0;
            dir_q     <= '0;
            dir_chg_q <= 1'b0;
            char_q    <= 7'h20;
        end else begin
            sync1_q <= ir;
            sync2_q <= sync1_q;
            if (s_sync != cand_q) begin
                cand_q <= s_sync;
                cnt_q  <= '0;
            end else if (cnt_q < CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                stable_q <= cand_q;
            end
            if (frame_tick) begin
                dir_q     <= dec;
                dir_chg_q <= (dec != dir_q);
            end else begin
                dir_chg_q <= 1'b0;
            end
            char_q <= char_d;
        end
    end

    assign char_addr_TEXT = char_q;
    assign dir            = dir_q;
    assign dir_changed    = dir_chg_q;

endmodule
